// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter and its picker.
package mult_arb_pkg;

    localparam int OPW         = 32;
    localparam int PRODW       = 64;
    localparam int TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Index arithmetic modulo n, valid for base < n and off <= n.
    function automatic int wrap_inc(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [IDW-1:0] idx_s;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'(wrap_inc(int'(ptr), k, NREQ));
            if (!any && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative signed multiplier among NREQ requesters with round-robin
// arbitration, a single tagged response port and a completion watchdog.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [PRODW-1:0]     rsp_product,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [OPW-1:0]       mul_a,
    output logic [OPW-1:0]       mul_b,
    input  logic                 mul_done,
    input  logic [PRODW-1:0]     mul_product
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_e      state_r, state_s;
    logic [IDW-1:0]  rr_ptr_r, gnt_id_r, pick_idx_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic            pick_any_s, accept_s, wait_done_s, wd_fire_s, rsp_hs_s;
    logic [WDW-1:0]  wd_cnt_r;
    logic [OPW-1:0]  sel_a_s, sel_b_s;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (pick_gnt_s),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Operand mux for the current pick, built from constant slices.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx_s == IDW'(k)) begin
                sel_a_s = req_a[k*OPW +: OPW];
                sel_b_s = req_b[k*OPW +: OPW];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Next-state decode; req_ready is combinational and only ever raised in IDLE.
    always_comb begin
        state_s     = state_r;
        req_ready   = '0;
        accept_s    = 1'b0;
        wait_done_s = 1'b0;
        wd_fire_s   = 1'b0;
        rsp_hs_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s && !rst) begin
                    accept_s  = 1'b1;
                    req_ready = pick_gnt_s;
                    state_s   = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (mul_done) begin
                    wait_done_s = 1'b1;
                    state_s     = RESP;
                end else if (wd_cnt_r == WDW'(TIMEOUT - 1)) begin
                    wd_fire_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_hs_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, grant bookkeeping, operand latch, start pulse and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            gnt_id_r  <= '0;
            wd_cnt_r  <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            state_r   <= state_s;
            mul_start <= accept_s;
            if (accept_s) begin
                mul_a    <= sel_a_s;
                mul_b    <= sel_b_s;
                gnt_id_r <= pick_idx_s;
            end
            if (state_r == ISSUE) begin
                wd_cnt_r <= '0;
            end else if (state_r == WAIT && !mul_done) begin
                wd_cnt_r <= wd_cnt_r + 1'b1;
            end
            if (rsp_hs_s) begin
                rr_ptr_r <= IDW'(wrap_inc(int'(gnt_id_r), 1, NREQ));
            end
        end
    end

    // Response registers stay frozen from capture until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else if (wait_done_s) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id_r;
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
        end else if (wd_fire_s) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id_r;
            rsp_product <= '0;
            rsp_err     <= 1'b1;
        end else if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a transaction-level model checks every cycle,
// literal expectations pin the model on the key scenarios.
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int TO = 40;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_product;
    logic           mul_start, mul_done;
    logic [31:0]    mul_a, mul_b;
    logic [63:0]    mul_product;

    int n_checks = 0;
    int n_pass   = 0;

    mult_arbiter #(.NREQ(N), .IDW(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Bench multiplier: fixed latency after start, optional hang; reset by the same rst.
    int          mul_lat  = 33;
    bit          mul_hang = 1'b0;
    logic        mb_busy;
    int          mb_cnt;
    logic [63:0] mb_prod;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_busy <= 1'b0;
            mb_cnt  <= 0;
            mb_prod <= '0;
        end else if (mul_start) begin
            mb_busy <= 1'b1;
            mb_cnt  <= 1;
            mb_prod <= smul(mul_a, mul_b);
        end else if (mb_busy) begin
            mb_cnt <= mb_cnt + 1;
            if (mb_cnt == mul_lat) mb_busy <= 1'b0;
        end
    end
    assign mul_done    = mb_busy && (mb_cnt == mul_lat) && !mul_hang;
    assign mul_product = mb_prod;

    // Transaction model: one operation outstanding from accept to response handshake.
    bit          m_busy, m_pend, m_err;
    int          m_ptr, m_age, m_id;
    logic [31:0] m_a, m_b;
    logic [63:0] m_prod;
    int          rsp_count = 0;
    int          last_id;
    logic [63:0] last_prod;
    logic        last_err;
    int          grant_q[$];
    logic [63:0] prod_q[$];

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] exp_rr;
        int idx, win;
        if (rst) begin
            m_busy = 1'b0; m_pend = 1'b0; m_ptr = 0; m_age = 0;
        end else begin
            if (m_busy) m_age++;
            exp_rr = '0;
            win    = -1;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && req_valid[2'(idx)]) begin
                        win = idx;
                        exp_rr[2'(idx)] = 1'b1;
                    end
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_rr));
            check("mul_start", 64'(mul_start), 64'(m_busy && m_age == 1));
            if (m_busy && m_age == 1) begin
                check("mul_a", 64'(mul_a), 64'(m_a));
                check("mul_b", 64'(mul_b), 64'(m_b));
            end
            check("rsp_valid", 64'(rsp_valid), 64'(m_pend));
            if (m_pend) begin
                check("rsp_id", 64'(rsp_id), 64'(m_id));
                check("rsp_product", rsp_product, m_prod);
                check("rsp_err", 64'(rsp_err), 64'(m_err));
                if (rsp_ready) begin
                    last_id   = m_id;
                    last_prod = m_prod;
                    last_err  = m_err;
                    prod_q.push_back(rsp_product);
                    rsp_count++;
                    m_busy = 1'b0;
                    m_pend = 1'b0;
                    m_ptr  = (m_id + 1) % N;
                end
            end else if (m_busy) begin
                if (m_age >= 2 && mul_done) begin
                    m_pend = 1'b1; m_prod = smul(m_a, m_b); m_err = 1'b0;
                end else if (m_age >= 2 && m_age - 1 == TO) begin
                    m_pend = 1'b1; m_prod = 64'd0; m_err = 1'b1;
                end
            end else if (win >= 0) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = win;
                m_a    = req_a[win*32 +: 32];
                m_b    = req_b[win*32 +: 32];
                grant_q.push_back(win);
            end
        end
    end

    // One cycle of stimulus; accepted requesters drop their valid afterwards.
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[2'(i)]  = 1'b1;
    endtask

    task automatic wait_rsp(input int n);
        int target, budget;
        target = rsp_count + n;
        budget = 0;
        while (rsp_count < target && budget < 500) begin
            tick();
            budget++;
        end
        if (rsp_count < target) begin
            n_checks++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_count, target);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : global_bound
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int b, g0, cnt0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_product", rsp_product, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request: 7 * -3
        set_req(0, 32'd7, 32'hFFFF_FFFD);
        wait_rsp(1);
        check("t1_id", 64'(last_id), 64'd0);
        check("t1_prod", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
        check("t1_err", 64'(last_err), 64'd0);

        // Full contention from a clean pointer, then a second round
        pulse_reset();
        g0 = grant_q.size();
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd10);
        wait_rsp(4);
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd10);
        wait_rsp(4);
        for (int i = 0; i < 2 * N; i++) begin
            check("t2_grant", 64'(grant_q[g0 + i]), 64'(i % N));
            check("t2_prod", prod_q[prod_q.size() - 2 * N + i], 64'(10 * ((i % N) + 1)));
        end

        // Backpressure: 20 stalled cycles, competing request must wait
        rsp_ready = 1'b0;
        set_req(2, 32'd5, 32'd6);
        b = 0;
        while (!rsp_valid && b < 200) begin tick(); b++; end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL t3_rsp_wait: got rsp_valid 0 expected 1");
        end
        set_req(1, 32'd3, 32'd3);
        cnt0 = rsp_count;
        repeat (20) tick();
        check("t3_hold_valid", 64'(rsp_valid), 64'd1);
        check("t3_hold_id", 64'(rsp_id), 64'd2);
        check("t3_hold_prod", rsp_product, 64'd30);
        rsp_ready = 1'b1;
        tick();
        check("t3_release", 64'(rsp_count), 64'(cnt0 + 1));
        wait_rsp(1);
        check("t3_next_grant", 64'(grant_q[grant_q.size() - 1]), 64'd1);
        check("t3_next_prod", last_prod, 64'd9);

        // Watchdog, then a normal operation
        mul_hang = 1'b1;
        set_req(3, 32'd9, 32'd9);
        wait_rsp(1);
        check("t4_err", 64'(last_err), 64'd1);
        check("t4_prod", last_prod, 64'd0);
        check("t4_id", 64'(last_id), 64'd3);
        mul_hang = 1'b0;
        set_req(0, 32'd4, 32'd5);
        wait_rsp(1);
        check("t4_after_prod", last_prod, 64'd20);
        check("t4_after_err", 64'(last_err), 64'd0);

        // Operand extremes
        set_req(1, 32'h8000_0000, 32'h8000_0000);
        wait_rsp(1);
        check("t5_minmin", last_prod, 64'h4000_0000_0000_0000);
        set_req(2, 32'hFFFF_FFFF, 32'd1);
        wait_rsp(1);
        check("t5_neg1", last_prod, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset while waiting on the multiplier (pointer is 3 here)
        g0 = grant_q.size();
        set_req(3, 32'd2, 32'd3);
        b = 0;
        while (grant_q.size() == g0 && b < 50) begin tick(); b++; end
        repeat (6) tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_mul_start", 64'(mul_start), 64'd0);
        check("t6_mul_ab", {mul_a, mul_b}, 64'd0);
        check("t6_rsp_fields", rsp_product | 64'(rsp_id) | 64'(rsp_err), 64'd0);
        set_req(1, 32'd11, 32'd2);
        set_req(3, 32'd6, 32'd7);
        #1;
        check("t6_req_ready_in_rst", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        g0 = grant_q.size();
        wait_rsp(2);
        check("t6_first_grant", 64'(grant_q[g0]), 64'd1);
        check("t6_second_grant", 64'(grant_q[g0 + 1]), 64'd3);
        check("t6_last_prod", last_prod, 64'd42);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one iterative 32x32 signed multiplier among NREQ requesters. Each requester has a valid/ready operand port. The block round-robin arbitrates the requests, sequences the multiplier (start pulse, wait for done), and returns the 64-bit product tagged with the requester ID over a single valid/ready response port. A watchdog flags a multiplier that fails to finish.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, equal to clog2(NREQ)
TIMEOUT, 40, maximum cycles in WAIT before an error response is raised

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  one-hot accept pulse to the granted requester
req_a  in  NREQ*32  flattened multiplicands, two's complement; slice i = bits [32i+31:32i]
req_b  in  NREQ*32  flattened multipliers, two's complement
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  requester index of the response
rsp_product  out  64  signed product
rsp_err  out  1  watchdog fired; rsp_product is 0
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  32  latched multiplicand
mul_b  out  32  latched multiplier
mul_done  in  1  multiplier result valid (level or pulse)
mul_product  in  64  multiplier result

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, rr_ptr=0, wd_cnt=0, and all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b).
- IDLE: if any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Same cycle: assert req_ready for the winner only, combinationally.
  - On the clock edge: latch the winner's A/B into mul_a/mul_b and the winner's index into gnt_id, then go to ISSUE.
  - If no request is valid, stay in IDLE with req_ready=0.
- ISSUE: mul_start=1 for exactly this cycle; clear wd_cnt; go to WAIT.
- WAIT: mul_done is sampled only in this state. A done asserted during ISSUE is ignored.
  - On mul_done=1: capture mul_product into rsp_product, set rsp_err=0, go to RESP.
  - Otherwise wd_cnt increments. When wd_cnt==TIMEOUT-1 and done is still low: set rsp_product=0, rsp_err=1, go to RESP.
- RESP: rsp_valid=1 and rsp_id=gnt_id. rsp_product and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid && rsp_ready: rr_ptr = (gnt_id+1) mod NREQ, go to IDLE, and rsp_valid drops the next cycle.
- No pipelining: one operation in flight, and req_ready is never asserted outside IDLE.
- Latency: accept at cycle T, mul_start at T+1, rsp_valid one cycle after the mul_done sample. Minimum accept-to-accept is 4 cycles plus the multiplier latency plus response backpressure.
- Fairness: a requester that holds req_valid is granted within NREQ operations.
- Requester rules:
  - Operands must be stable while req_valid=1.
  - A requester may drop req_valid before it is granted, with no side effect.
  - Requester i sees exactly one req_ready pulse per accepted operation.
- Sign handling belongs to the multiplier. The arbiter passes operands and product through bit-exact, with no width change.
- Simultaneous events: with all requesters valid in IDLE, rr_ptr decides. rsp_ready asserted before RESP has no effect.
- Reset mid-operation: an in-flight result is discarded and nothing is returned. The multiplier must also be reset by the same rst.

Decomposition:
- Shared package mult_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}, 2 bits
  - constants OPW=32 and PRODW=64
  - the default TIMEOUT value
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant, grant index, any. Reused by later arbiters.
- The FSM, operand/response registers and watchdog live in mult_arbiter.

Test Plan:
- Single request: req_valid=0001, A=7, B=-3, model multiplier latency 33 -> req_ready=0001 for one cycle, one mul_start pulse, then rsp_id=0, rsp_product=64'hFFFF_FFFF_FFFF_FFEB (-21), rsp_err=0.
- Full contention: all four requesters valid, each with A=i+1 and B=10, held until accepted -> grant order 0,1,2,3, products 10,20,30,40, each with the matching rsp_id. Hold all valid again -> grants continue 0,1,... (rr_ptr wraps).
- Backpressure: rsp_ready=0 for 20 cycles in RESP -> rsp_valid, rsp_product and rsp_id stay stable, no new req_ready and no mul_start. Release -> handshake completes in one cycle and the next grant follows.
- Watchdog: multiplier model never asserts done -> after TIMEOUT=40 WAIT cycles, rsp_valid=1, rsp_err=1, rsp_product=0. The next request then completes normally.
- Extremes: A=32'h8000_0000, B=32'h8000_0000 -> rsp_product = the multiplier's output, passed bit-exact. A=-1, B=1 -> rsp_product=64'hFFFF_FFFF_FFFF_FFFF.
- Reset in WAIT: assert rst asynchronously mid-operation -> all outputs 0 immediately, state IDLE, rr_ptr=0, no stale response after release. A request after release is granted to the lowest valid index.
